// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the memory-mapped UART transmitter port.
//   The bus multiplexer uses the two address constants to decode the data
//   write and the status read. uart_tx_port uses the state enum, the status
//   bit indices and the status packing helper.
//
//   Contents:
//     tx_state_e    transmitter FSM states (IDLE, START, DATA, STOP)
//     TX_DATA_ADDR  bus address of the byte-to-send register
//     TX_STAT_ADDR  bus address of the status word
//     STAT_*        bit positions inside the 16-bit status word
//     FRAME_BITS    bits per 8N1 frame (start + 8 data + stop)
//     packStatus()  builds the status word from its three flags
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [15:0] TX_DATA_ADDR = 16'h0a00;
  localparam logic [15:0] TX_STAT_ADDR = 16'h0a01;

  localparam int STAT_READY = 0;
  localparam int STAT_IDLE  = 1;
  localparam int STAT_OVF   = 2;

  localparam int FRAME_BITS = 10;

  // The upper status bits are reserved and always read as zero, so the
  // word is built from a cleared value and only the three flags are set.
  function automatic logic [15:0] packStatus(input logic ovf,
                                             input logic idle,
                                             input logic ready);
    logic [15:0] word;
    word             = 16'h0000;
    word[STAT_OVF]   = ovf;
    word[STAT_IDLE]  = idle;
    word[STAT_READY] = ready;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Small synchronous FIFO that holds the bytes queued for transmission.
//   The head entry is visible on o_data without a read latency, so the
//   consumer can load it on the same edge that pops it.
//
//   Parameters:
//     WIDTH  data width in bits
//     DEPTH  number of entries; must be a power of two and at least 2
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous active-high reset; empties the FIFO
//     i_push   in   store i_data at the next edge (ignored when it cannot fit)
//     i_pop    in   drop the head entry at the next edge (ignored when empty)
//     i_data   in   WIDTH  entry to store
//     o_data   out  WIDTH  current head entry
//     o_full   out  all DEPTH entries are occupied
//     o_empty  out  no entries are occupied
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  import uart_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;

  logic w_doPush;
  logic w_doPop;

  // The count carries one extra bit so that "all slots used" and
  // "no slots used" are different values even though the two pointers
  // are equal in both cases.
  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);

  // A push into a full FIFO is still accepted when a pop happens in the
  // same cycle: the pop frees the head slot, which is exactly the slot the
  // write pointer is aiming at, and the old head has already been consumed
  // from o_data before the edge.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  assign o_data = r_mem[r_rdPtr];

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because the
  // depth is a power of two; a simultaneous push and pop leaves the count
  // where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset: a flushed FIFO is defined by its pointers and
  // count, so stale bytes left in the array are never observable.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// ---------------------------------------------------------------------------
// uart_tx_port
//   Memory-mapped UART transmitter. The CPU polls the status word and, when
//   ready is set, writes a byte to the data address. Bytes are queued in a
//   small FIFO and sent 8N1, LSB first, on o_tx. Consecutive queued bytes go
//   out back to back with no idle time between the stop bit and the next
//   start bit. Each frame is exactly 10 * BIT_DIV clocks long.
//
//   Parameters:
//     CLK_FREQ    system clock frequency in Hz
//     BAUD        line rate in bit/s
//     BIT_DIV     clocks per bit, derived from the two above unless overridden
//     FIFO_DEPTH  byte FIFO depth; power of two, at least 2
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   asynchronous active-high reset
//     i_wr_strobe  in   one-cycle pulse: CPU write to the TX data address
//     i_wr_data    in   8   byte to send
//     i_stat_rd    in   high while the CPU addresses the status word;
//                       clears the sticky overflow flag
//     o_status     out  16  {13'b0, ovf, idle, ready}
//     o_tx         out  serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_port #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int BIT_DIV    = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_strobe,
  input  logic [7:0]  i_wr_data,
  input  logic        i_stat_rd,
  output logic [15:0] o_status,
  output logic        o_tx
);
  import uart_pkg::*;

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  tx_state_e        r_state;
  tx_state_e        w_stateNext;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_divNext;
  logic [2:0]       r_bitIdx;
  logic [2:0]       w_bitIdxNext;
  logic [7:0]       r_shift;
  logic [7:0]       w_shiftNext;
  logic             r_tx;
  logic             w_txNext;
  logic             r_ovf;
  logic             w_ovfNext;

  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_fifoData;
  logic             w_divEnd;
  logic             w_overflow;
  logic             w_idle;

  // Byte queue between the CPU and the serialiser. Every strobe is offered
  // to the FIFO; it decides for itself whether the byte fits.
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_wr_strobe),
    .i_pop   (w_pop),
    .i_data  (i_wr_data),
    .o_data  (w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_divEnd = (r_div == DIV_LAST);

  // A write is only lost when the FIFO is full and nothing leaves it in
  // the same cycle; a pop at the end of a stop bit makes room in time.
  assign w_overflow = i_wr_strobe && w_full && !w_pop;

  // Sticky overflow flag. Setting takes priority, so an overflow that
  // coincides with a status read is still reported on the next read.
  always_comb begin
    w_ovfNext = r_ovf;
    if (w_overflow) begin
      w_ovfNext = 1'b1;
    end else if (i_stat_rd) begin
      w_ovfNext = 1'b0;
    end
  end

  // Next-state logic for the serialiser. The divider free-runs through
  // 0..BIT_DIV-1 inside a state and is cleared on every state change, so
  // each of the ten bit slots lasts exactly BIT_DIV clocks. The head of the
  // FIFO is popped straight into the shift register either from IDLE or at
  // the end of a stop bit, which is what makes back-to-back frames gapless.
  always_comb begin
    w_stateNext  = r_state;
    w_divNext    = w_divEnd ? '0 : r_div + DIV_W'(1);
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_pop        = 1'b0;

    case (r_state)
      IDLE: begin
        w_divNext = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shiftNext = w_fifoData;
          w_stateNext = START;
        end
      end
      START: begin
        if (w_divEnd) begin
          w_stateNext  = DATA;
          w_bitIdxNext = '0;
        end
      end
      DATA: begin
        if (w_divEnd) begin
          w_shiftNext = {1'b0, r_shift[7:1]};
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_divEnd) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shiftNext = w_fifoData;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    if (w_stateNext != r_state) begin
      w_divNext = '0;
    end
  end

  // The line level is registered so o_tx is glitch-free. It is derived
  // from where the FSM is going next, which puts the start bit on the line
  // on the edge that pops the byte.
  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      default: w_txNext = 1'b1;
    endcase
  end

  // State register. Reset is asynchronous so a reset mid-frame returns the
  // line to idle-high at once and truncates the frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_div    <= w_divNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
      r_ovf    <= w_ovfNext;
    end
  end

  // Idle means nothing is on the line and nothing is waiting, so software
  // can use it to know the last byte has fully left the port.
  assign w_idle = (r_state == IDLE) && w_empty;

  assign o_status = packStatus(r_ovf, w_idle, !w_full);
  assign o_tx     = r_tx;

endmodule

// File: tb/tb_uart_tx_port.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_port
//   Self-checking bench for uart_tx_port with BIT_DIV = 4, FIFO_DEPTH = 4.
//   A reference model of the port (queue occupancy plus frame position)
//   predicts the line level and status word every clock. An independent
//   line decoder recovers the bytes actually sent so directed steps can
//   compare them against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx_port;

  localparam int BIT_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * BIT_DIV;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        wrStrobe = 1'b0;
  logic [7:0]  wrData   = 8'h00;
  logic        statRd   = 1'b0;
  logic [15:0] status;
  logic        tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_port #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (9600),
    .BIT_DIV    (BIT_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_strobe (wrStrobe),
    .i_wr_data   (wrData),
    .i_stat_rd   (statRd),
    .o_status    (status),
    .o_tx        (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes waiting to be sent, bytes ever accepted, and the position inside
  // the frame currently on the line (-1 when the line is free).
  logic [7:0] modelQ[$];
  logic [7:0] acceptLog[$];
  int         frmOff   = -1;
  logic [7:0] frmByte  = 8'h00;
  logic       modelOvf = 1'b0;

  function automatic logic frameBit(input logic [7:0] b, input int off);
    int slot;
    slot = off / BIT_DIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[3'(slot - 1)];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      frmOff   = -1;
      modelOvf = 1'b0;
    end else begin
      logic rejected;
      rejected = 1'b0;
      if (frmOff >= 0) begin
        frmOff++;
        if (frmOff == FRAME) frmOff = -1;
      end
      if (frmOff < 0 && modelQ.size() > 0) begin
        frmByte = modelQ.pop_front();
        frmOff  = 0;
      end
      if (wrStrobe) begin
        if (modelQ.size() < DEPTH) begin
          modelQ.push_back(wrData);
          acceptLog.push_back(wrData);
        end else begin
          rejected = 1'b1;
        end
      end
      if (rejected) modelOvf = 1'b1;
      else if (statRd) modelOvf = 1'b0;
    end
  end

  // ---------------- per-cycle check and line decoder ----------------
  logic [7:0] decQ[$];
  int         decStarts[$];
  logic       decActive = 1'b0;
  int         decCyc    = 0;
  logic [7:0] decByte   = 8'h00;

  always @(negedge clk) begin
    logic        expTx;
    logic [15:0] expStatus;
    expTx     = (frmOff < 0) ? 1'b1 : frameBit(frmByte, frmOff);
    expStatus = {13'b0, modelOvf, (frmOff < 0) && (modelQ.size() == 0), modelQ.size() < DEPTH};
    checkOutput("model_tx", {15'b0, tx}, {15'b0, expTx});
    checkOutput("model_status", status, expStatus);

    if (rst) begin
      decActive = 1'b0;
    end else if (!decActive) begin
      if (tx == 1'b0) begin
        decActive = 1'b1;
        decCyc    = 0;
        decByte   = 8'h00;
        decStarts.push_back(cyc);
      end
    end else begin
      decCyc++;
      if (decCyc >= 6 && decCyc <= 34 && ((decCyc - 6) % BIT_DIV) == 0)
        decByte[3'((decCyc - 6) / BIT_DIV)] = tx;
      if (decCyc == FRAME - 1) begin
        decQ.push_back(decByte);
        decActive = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; the strobe is sampled by the next rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    wrData   = b;
    wrStrobe = 1'b1;
    @(negedge clk);
    wrStrobe = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n;
    n = 0;
    while (status[1] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {15'b0, status[1]}, 16'h0001);
  endtask

  task automatic clearLogs();
    decQ.delete();
    decStarts.delete();
    acceptLog.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         issue;
    logic [39:0] line;
    logic [9:0]  a5Line;
    logic [7:0]  t5Bytes[3];
    logic [7:0]  t6Bytes[6];

    a5Line = 10'b1101001010;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_status", status, 16'h0003);
    checkOutput("reset_tx", {15'b0, tx}, 16'h0001);
    rst = 1'b0;

    // 1: quiet port after reset
    $display("[TB] step 1: idle after reset");
    repeat (20) begin
      @(negedge clk);
      checkOutput("t1_status", status, 16'h0003);
      checkOutput("t1_tx", {15'b0, tx}, 16'h0001);
    end

    // 2: single byte A5, exact waveform and latency
    $display("[TB] step 2: single byte");
    clearLogs();
    issue = cyc;
    applyStimulus(8'hA5);
    checkOutput("t2_tx_before_start", {15'b0, tx}, 16'h0001);
    @(negedge clk);
    line    = '0;
    line[0] = tx;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      line[i] = tx;
    end
    for (int i = 0; i < FRAME; i++)
      checkOutput("t2_line_bit", {15'b0, line[i]}, {15'b0, a5Line[i / BIT_DIV]});
    @(negedge clk);
    checkOutput("t2_status_after", status, 16'h0003);
    checkOutput("t2_tx_after", {15'b0, tx}, 16'h0001);
    checkOutput("t2_frames", 16'(decQ.size()), 16'd1);
    if (decQ.size() == 1) checkOutput("t2_byte", {8'h00, decQ[0]}, 16'h00A5);
    if (decStarts.size() == 1) checkOutput("t2_start_edge", 16'(decStarts[0] - issue), 16'd2);

    // 3: three consecutive writes, gapless frames
    $display("[TB] step 3: back-to-back frames");
    clearLogs();
    issue = cyc;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    checkOutput("t3_busy", {15'b0, status[1]}, 16'h0000);
    repeat (118) begin
      @(negedge clk);
      checkOutput("t3_busy", {15'b0, status[1]}, 16'h0000);
    end
    @(negedge clk);
    checkOutput("t3_idle_after", {15'b0, status[1]}, 16'h0001);
    checkOutput("t3_frames", 16'(decQ.size()), 16'd3);
    for (int i = 0; i < 3 && i < decQ.size(); i++)
      checkOutput("t3_byte", {8'h00, decQ[i]}, 16'(i + 1));
    if (decStarts.size() == 3) begin
      checkOutput("t3_first_start", 16'(decStarts[0] - issue), 16'd2);
      checkOutput("t3_gap12", 16'(decStarts[1] - decStarts[0]), 16'(FRAME));
      checkOutput("t3_gap23", 16'(decStarts[2] - decStarts[1]), 16'(FRAME));
    end

    // 4: six writes overflow a four-deep FIFO
    $display("[TB] step 4: overflow");
    clearLogs();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h10 + i));
    checkOutput("t4_status_ovf", status, 16'h0004);
    waitIdle(400, "t4_wait_idle");
    checkOutput("t4_status_done", status, 16'h0007);
    checkOutput("t4_frames", 16'(decQ.size()), 16'd5);
    for (int i = 0; i < 5 && i < decQ.size(); i++)
      checkOutput("t4_byte", {8'h00, decQ[i]}, 16'(8'h10 + i));
    statRd = 1'b1;
    @(negedge clk);
    statRd = 1'b0;
    checkOutput("t4_ovf_cleared", status, 16'h0003);

    // 5: reset in the middle of the data bits with bytes queued
    $display("[TB] step 5: reset mid-frame");
    clearLogs();
    for (int i = 0; i < 3; i++) begin
      t5Bytes[i] = 8'($urandom);
      applyStimulus(t5Bytes[i]);
    end
    repeat (15) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_tx_async", {15'b0, tx}, 16'h0001);
    checkOutput("t5_status_async", status, 16'h0003);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("t5_frames_after", 16'(decQ.size()), 16'd0);
    checkOutput("t5_status_after", status, 16'h0003);

    // 6: write lands on the same edge as the stop-bit pop of a full FIFO
    $display("[TB] step 6: push and pop together while full");
    clearLogs();
    for (int i = 0; i < 5; i++) begin
      t6Bytes[i] = 8'($urandom);
      applyStimulus(t6Bytes[i]);
    end
    repeat (36) @(negedge clk);
    checkOutput("t6_full_before", status, 16'h0000);
    t6Bytes[5] = 8'($urandom);
    applyStimulus(t6Bytes[5]);
    checkOutput("t6_no_ovf", status, 16'h0000);
    waitIdle(400, "t6_wait_idle");
    checkOutput("t6_status_done", status, 16'h0003);
    checkOutput("t6_frames", 16'(decQ.size()), 16'd6);
    for (int i = 0; i < 6 && i < decQ.size(); i++)
      checkOutput("t6_byte", {8'h00, decQ[i]}, {8'h00, t6Bytes[i]});

    // 7: random traffic against the model
    $display("[TB] step 7: random traffic");
    clearLogs();
    for (int i = 0; i < 800; i++) begin
      wrStrobe = ($urandom_range(0, 9) == 0);
      wrData   = 8'($urandom);
      statRd   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    wrStrobe = 1'b0;
    statRd   = 1'b0;
    waitIdle(1000, "t7_wait_idle");
    checkOutput("t7_frames", 16'(decQ.size()), 16'(acceptLog.size()));
    for (int i = 0; i < decQ.size() && i < acceptLog.size(); i++)
      checkOutput("t7_byte", {8'h00, decQ[i]}, {8'h00, acceptLog[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
